// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared mini-ALU controller: opcode encodings
// and the controller FSM state type.
package alu_share_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational mini-ALU: bitwise ops plus an unsigned add with carry-out.
// Carry is only meaningful for ADD and is forced low for every other op.
module alu_core
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = a ~^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOTA: y = ~a;
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one mini-ALU between two requesters:
// accept in IDLE, compute in EXEC, hold the tagged result in RESP until taken.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_grant;
  logic             grant0, grant1, accept;
  logic [OPW-1:0]   op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             id_p0;
  logic [WIDTH-1:0] core_y;
  logic             core_carry;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) last_grant <= grant1;
      // EXEC -> RESP boundary: register the core output into the response.
      if (state_q == ST_EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_p0;
        rsp_result <= core_y;
        rsp_zero   <= (core_y == '0);
        rsp_carry  <= core_carry;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // IDLE -> EXEC boundary: operands are captured only at the handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0 <= grant1;
      op_p0 <= grant1 ? req1_op : req0_op;
      a_p0  <= grant1 ? req1_a  : req0_a;
      b_p0  <= grant1 ? req1_b  : req0_b;
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .op    (op_p0),
    .a     (a_p0),
    .b     (b_p0),
    .y     (core_y),
    .carry (core_carry)
  );

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [5:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, busy;
  logic [5:0] rsp_result;

  int tests = 0;
  int fails = 0;
  logic tb_last;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(6), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written with integer arithmetic on the opcode table.
  task automatic ref_alu(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                         output logic [5:0] res, output logic cy);
    int ia, ib, r;
    ia = a; ib = b; cy = 1'b0;
    case (op)
      3'd0: r = ia & ib;
      3'd1: r = ia | ib;
      3'd2: r = ia ^ ib;
      3'd3: r = 63 - (ia ^ ib);
      3'd4: r = 63 - (ia & ib);
      3'd5: r = 63 - (ia | ib);
      3'd6: r = 63 - ia;
      default: begin r = (ia + ib) % 64; cy = (ia + ib) > 63; end
    endcase
    res = r[5:0];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction from the accept cycle to the cycle after the
  // response is taken; rsp_ready is withheld for 'hold' cycles of RESP.
  task automatic txn(input logic exp_id, input logic [5:0] exp_res, input logic exp_cy,
                     input int hold, input bit scramble);
    #1;
    chk("req0_ready_accept", req0_ready, exp_id == 1'b0);
    chk("req1_ready_accept", req1_ready, exp_id == 1'b1);
    rsp_ready = 1'b1;
    tick();
    if (scramble) begin
      req0_a = 6'($urandom); req0_b = 6'($urandom); req0_op = 3'($urandom);
      req1_a = 6'($urandom); req1_b = 6'($urandom); req1_op = 3'($urandom);
    end
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_rsp_valid", rsp_valid, 1'b0);
    chk("exec_readies", {req0_ready, req1_ready}, 2'b00);
    tick();
    for (int i = 0; i <= hold; i++) begin
      rsp_ready = (i == hold);
      #1;
      chk("resp_valid", rsp_valid, 1'b1);
      chk("resp_id", rsp_id, exp_id);
      chk("resp_result", rsp_result, exp_res);
      chk("resp_zero", rsp_zero, exp_res == 6'd0);
      chk("resp_carry", rsp_carry, exp_cy);
      chk("resp_busy", busy, 1'b1);
      chk("resp_readies", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    chk("after_valid", rsp_valid, 1'b0);
    chk("after_busy", busy, 1'b0);
    tb_last = exp_id;
  endtask

  logic [5:0] er;
  logic       ec, v0, v1, eg;
  logic [2:0] sop;
  logic [5:0] sweep_exp [8];
  int         hold;

  initial begin
    sweep_exp = '{6'h03, 6'h3F, 6'h3C, 6'h03, 6'h3C, 6'h00, 6'h0C, 6'h02};
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 6'h3F; req0_b = 6'h01;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 6'h00; req1_b = 6'h00;
    tick(); tick();
    chk("rst_readies", {req0_ready, req1_ready}, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", rsp_result, 6'h00);
    chk("rst_flags", {rsp_id, rsp_zero, rsp_carry}, 3'b000);
    tb_last = 1'b1;

    // Single request: 3F + 01 wraps to zero with carry.
    req1_valid = 1'b0;
    rst = 1'b0;
    txn(1'b0, 6'h00, 1'b1, 0, 1'b0);

    // Contention: grants must alternate.
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 6'h2A; req0_b = 6'h0F;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 6'h2A; req1_b = 6'h0F;
    for (int k = 0; k < 4; k++) begin
      eg = !tb_last;
      txn(eg, eg ? 6'h0A : 6'h1A, 1'b0, 0, 1'b0);
    end

    // Backpressure: five stalled RESP cycles.
    req1_valid = 1'b0; req0_op = 3'd7; req0_a = 6'h20; req0_b = 6'h21;
    txn(1'b0, 6'h01, 1'b1, 5, 1'b0);

    // Operand change after acceptance of NOT A.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 6'h15; req1_b = 6'h3F;
    txn(1'b1, 6'h2A, 1'b0, 1, 1'b1);

    // Reset while holding a response.
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 6'h11; req0_b = 6'h22;
    rsp_ready = 1'b0;
    tick(); tick();
    req0_valid = 1'b0;
    #1;
    chk("pre_rst_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_readies", {req0_ready, req1_ready}, 2'b00);
    tick();
    chk("post_rst_valid", rsp_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_outs", {rsp_id, rsp_zero, rsp_carry, rsp_result}, 9'd0);
    rst = 1'b0; tb_last = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 6'h0F; req0_b = 6'h0F;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 6'h01; req1_b = 6'h02;
    txn(1'b0, 6'h00, 1'b0, 0, 1'b0);

    // Opcode sweep against the fixed result table.
    req1_valid = 1'b0; req0_a = 6'h33; req0_b = 6'h0F;
    for (int k = 0; k < 8; k++) begin
      req0_op = 3'(k);
      txn(1'b0, sweep_exp[k], k == 7, 0, 1'b0);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 60; k++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      req0_valid = v0; req0_op = 3'($urandom); req0_a = 6'($urandom); req0_b = 6'($urandom);
      req1_valid = v1; req1_op = 3'($urandom); req1_a = 6'($urandom); req1_b = 6'($urandom);
      if (!v0 && !v1) begin
        #1;
        chk("idle_readies", {req0_ready, req1_ready}, 2'b00);
        chk("idle_busy", busy, 1'b0);
        tick();
      end else begin
        eg = (v0 && v1) ? !tb_last : v1;
        if (eg) ref_alu(req1_op, req1_a, req1_b, er, ec);
        else    ref_alu(req0_op, req0_a, req0_b, er, ec);
        sop = 3'($urandom);
        hold = $urandom_range(0, 3);
        txn(eg, er, ec, hold, sop[0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter sharing one 6-bit mini-ALU datapath (bitwise ops + add) between two requesters.
- Each requester presents an opcode and operands with a valid/ready handshake.
- Block arbitrates round-robin, latches operands, executes in a registered stage, and returns a tagged result with zero/carry flags over a valid/ready response channel.
- Sits between the mini-ALU's front-end ports (switch/UART/test sources) and the output display/log logic.

Parameters:
- WIDTH, 6, operand/result width in bits
- OPW, 3, opcode width

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OPW  requester 0 opcode
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index owning the result
- rsp_result  out  WIDTH  operation result
- rsp_zero  out  1  rsp_result == 0
- rsp_carry  out  1  carry-out; ADD only, 0 for all other ops
- busy  out  1  state != IDLE

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 XNOR (a ~^ b), 100 NAND, 101 NOR, 110 NOT A (b ignored), 111 ADD.
- ADD: {carry, result} = a + b, WIDTH+1 bits, no saturation, wraps modulo 2^WIDTH.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, grant that requester. If both are high, grant the one not equal to last_grant.
  - reqN_ready = (state==IDLE) && grantN. The ready for the requester not granted stays 0.
  - On a handshake (valid && ready): latch op/a/b/id, set last_grant = id, go to EXEC.
  - With no valid requester, stay in IDLE with both readies 0.
- EXEC: one cycle. Compute through the core and register result, zero and carry into the response registers. Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_result and flags stable until rsp_ready=1.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - Both reqN_ready are 0 throughout.
- Latency: accept in cycle 0, rsp_valid in cycle 2. With rsp_ready held high, the next accept is in cycle 3, so peak throughput is one op per 3 cycles.
- Requester inputs are sampled only at the handshake. Changes after acceptance do not affect the in-flight op.
- rsp_ready while rsp_valid=0 is ignored.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_carry=0, busy=0, last_grant=1 (so req0 wins the first tie), reqN_ready=0 during the reset cycle.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is produced, all reset values apply on the next cycle.
- Fairness: under continuous contention, grants alternate 0,1,0,1… No requester waits more than one other op.

Decomposition:
- Shared header alu_defs.vh holds the opcode localparams (OP_AND…OP_ADD) and FSM state encodings (ST_IDLE, ST_EXEC, ST_RESP). The existing ALU units and the bench use the same header.
- Sub-module alu_core:
  - Purely combinational: op, a, b -> y, carry.
  - Instantiates or mirrors the existing bitwise units and the adder.
  - Instantiated once in the controller.

Test Plan:
- Single request: req0 ADD a=6'h3F, b=6'h01, rsp_ready=1. Expect req0_ready in cycle 0; rsp_valid in cycle 2 with result=6'h00, zero=1, carry=1, id=0.
- Contention: both requesters valid every cycle. req0 XNOR 6'h2A/6'h0F, req1 AND 6'h2A/6'h0F. Expect grants 0,1,0,1; results 6'h1A (id 0) and 6'h0A (id 1) alternating; carry=0 for both.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Expect result/flags stable, busy=1, both readies 0. Raise rsp_ready: rsp_valid drops next cycle, a new accept follows one cycle later.
- Operand change: alter req1_a on the cycle after acceptance of NOT A with a=6'h15. Expect result=6'h2A.
- Reset in RESP: assert rst while rsp_valid=1. Next cycle: rsp_valid=0, busy=0, all outputs 0. A subsequent tie grants req0.
- Opcode sweep: all 8 ops with a=6'h33, b=6'h0F. Expect 03, 3F, 3C, 03, 3C, 00 (zero=1), 0C, 02 (carry=1).
